// File: rtl/branch_redirect.sv
// rtl/branch_redirect.sv - execute-stage branch/jump redirect with fetch-stall hold
//
// Decides whether the instruction in execute redirects fetch, drives the fetch
// next-PC select and the decode/execute flushes. Defers the redirect while fetch
// is stalled, latches a sticky misaligned-target flag and keeps saturating
// branch statistics.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   valid_execute                execute stage holds a real instruction
//   branch_execute               conditional branch
//   jump_execute                 JAL
//   jump_reg_execute             JALR
//   funct3_execute               branch condition code
//   rs1_execute, rs2_execute     compare operands
//   pc_plus_imm_execute          PC-relative target (branches, JAL)
//   alu_result_execute           register-relative target (JALR)
//   stall_fetch                  fetch PC register held this cycle
//   pc_source                    fetch next-PC mux select
//   flush_decode, flush_execute  squash decode/execute registers at next edge
//   misaligned_fetch             sticky misaligned-target flag
//   branch_count, taken_count    saturating statistics

`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_SRC_BITS_COUNT
`define PC_SRC_BITS_COUNT 2
`endif
`ifndef PC_SRC_PC_PLUS_4
`define PC_SRC_PC_PLUS_4 2'd0
`endif
`ifndef PC_SRC_PC_PLUS_IMM
`define PC_SRC_PC_PLUS_IMM 2'd1
`endif
`ifndef PC_SRC_GPR_PLUS_IMM
`define PC_SRC_GPR_PLUS_IMM 2'd2
`endif

module branch_redirect (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          valid_execute,
   input  logic                          branch_execute,
   input  logic                          jump_execute,
   input  logic                          jump_reg_execute,
   input  logic [2:0]                    funct3_execute,
   input  logic [`XLEN-1:0]              rs1_execute,
   input  logic [`XLEN-1:0]              rs2_execute,
   input  logic [`XLEN-1:0]              pc_plus_imm_execute,
   input  logic [`XLEN-1:0]              alu_result_execute,
   input  logic                          stall_fetch,
   output logic [`PC_SRC_BITS_COUNT-1:0] pc_source,
   output logic                          flush_decode,
   output logic                          flush_execute,
   output logic                          misaligned_fetch,
   output logic [31:0]                   branch_count,
   output logic [31:0]                   taken_count
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0]                    state_q, state_d;
   logic [`PC_SRC_BITS_COUNT-1:0] held_sel_q, held_sel_d;
   logic                          held_branch_q, held_branch_d;

   logic                          cond;
   logic                          take;
   logic                          is_cond_branch;
   logic [`XLEN-1:0]              target;
   logic                          misaligned;
   logic [`PC_SRC_BITS_COUNT-1:0] sel;
   logic                          flush;
   logic                          redirect_branch;
   logic                          count_branch;

   always_comb begin
      cond = 1'b0;
      case (funct3_execute)
         3'b000:  cond = (rs1_execute == rs2_execute);
         3'b001:  cond = (rs1_execute != rs2_execute);
         3'b100:  cond = ($signed(rs1_execute) <  $signed(rs2_execute));
         3'b101:  cond = ($signed(rs1_execute) >= $signed(rs2_execute));
         3'b110:  cond = (rs1_execute <  rs2_execute);
         3'b111:  cond = (rs1_execute >= rs2_execute);
         default: cond = 1'b0;
      endcase
   end

   // Jump flags dominate: an instruction flagged both jump and branch is a jump
   // and is neither evaluated nor counted as a taken conditional branch.
   assign take           = valid_execute & (jump_execute | jump_reg_execute | (branch_execute & cond));
   assign is_cond_branch = branch_execute & ~jump_execute & ~jump_reg_execute;
   assign target         = jump_reg_execute ? {alu_result_execute[`XLEN-1:1], 1'b0}
                                            : pc_plus_imm_execute;
   assign misaligned     = take & target[1];
   assign sel            = jump_reg_execute ? `PC_SRC_GPR_PLUS_IMM : `PC_SRC_PC_PLUS_IMM;

   always_comb begin
      pc_source       = `PC_SRC_PC_PLUS_4;
      flush           = 1'b0;
      state_d         = state_q;
      held_sel_d      = held_sel_q;
      held_branch_d   = held_branch_q;
      redirect_branch = 1'b0;
      if (!reset) begin
         case (state_q)
            IDLE: begin
               if (take && !misaligned) begin
                  if (!stall_fetch) begin
                     pc_source       = sel;
                     flush           = 1'b1;
                     redirect_branch = is_cond_branch;
                  end else begin
                     held_sel_d    = sel;
                     held_branch_d = is_cond_branch;
                     state_d       = HOLD;
                  end
               end
            end
            HOLD: begin
               // Execute inputs are frozen by the hazard unit, so only the
               // latched select is replayed; the decision is not recomputed.
               if (!stall_fetch) begin
                  pc_source       = held_sel_q;
                  flush           = 1'b1;
                  redirect_branch = held_branch_q;
                  state_d         = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign flush_decode  = flush;
   assign flush_execute = flush;
   assign count_branch  = (state_q == IDLE) & valid_execute & branch_execute & ~stall_fetch;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         held_sel_q       <= `PC_SRC_PC_PLUS_4;
         held_branch_q    <= 1'b0;
         misaligned_fetch <= 1'b0;
         branch_count     <= 32'd0;
         taken_count      <= 32'd0;
      end else begin
         state_q       <= state_d;
         held_sel_q    <= held_sel_d;
         held_branch_q <= held_branch_d;
         if ((state_q == IDLE) && misaligned)
            misaligned_fetch <= 1'b1;
         if (count_branch && (branch_count != 32'hFFFF_FFFF))
            branch_count <= branch_count + 32'd1;
         if (redirect_branch && (taken_count != 32'hFFFF_FFFF))
            taken_count <= taken_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_redirect.sv
// tb/tb_branch_redirect.sv - self-checking bench for branch_redirect

`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_SRC_BITS_COUNT
`define PC_SRC_BITS_COUNT 2
`endif
`ifndef PC_SRC_PC_PLUS_4
`define PC_SRC_PC_PLUS_4 2'd0
`endif
`ifndef PC_SRC_PC_PLUS_IMM
`define PC_SRC_PC_PLUS_IMM 2'd1
`endif
`ifndef PC_SRC_GPR_PLUS_IMM
`define PC_SRC_GPR_PLUS_IMM 2'd2
`endif

module tb_branch_redirect;

   logic                          clk = 1'b0;
   logic                          reset;
   logic                          valid_execute;
   logic                          branch_execute;
   logic                          jump_execute;
   logic                          jump_reg_execute;
   logic [2:0]                    funct3_execute;
   logic [`XLEN-1:0]              rs1_execute;
   logic [`XLEN-1:0]              rs2_execute;
   logic [`XLEN-1:0]              pc_plus_imm_execute;
   logic [`XLEN-1:0]              alu_result_execute;
   logic                          stall_fetch;
   logic [`PC_SRC_BITS_COUNT-1:0] pc_source;
   logic                          flush_decode;
   logic                          flush_execute;
   logic                          misaligned_fetch;
   logic [31:0]                   branch_count;
   logic [31:0]                   taken_count;

   always #5 clk = ~clk;

   branch_redirect dut (
      .clk                 (clk),
      .reset               (reset),
      .valid_execute       (valid_execute),
      .branch_execute      (branch_execute),
      .jump_execute        (jump_execute),
      .jump_reg_execute    (jump_reg_execute),
      .funct3_execute      (funct3_execute),
      .rs1_execute         (rs1_execute),
      .rs2_execute         (rs2_execute),
      .pc_plus_imm_execute (pc_plus_imm_execute),
      .alu_result_execute  (alu_result_execute),
      .stall_fetch         (stall_fetch),
      .pc_source           (pc_source),
      .flush_decode        (flush_decode),
      .flush_execute       (flush_execute),
      .misaligned_fetch    (misaligned_fetch),
      .branch_count        (branch_count),
      .taken_count         (taken_count)
   );

   typedef struct {
      logic [1:0] pc;
      logic       fd;
      logic       fe;
   } exp_t;

   exp_t        sbq[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_bc;
   logic [31:0] exp_tc;
   exp_t        e;

   task automatic sb_push(input logic [1:0] pc, input logic fl);
      exp_t x;
      x.pc = pc;
      x.fd = fl;
      x.fe = fl;
      sbq.push_back(x);
   endtask

   function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int signed sa;
      int signed sb;
      sa = a;
      sb = b;
      if (f == 3'd0) return a == b;
      if (f == 3'd1) return a != b;
      if (f == 3'd4) return sa < sb;
      if (f == 3'd5) return !(sa < sb);
      if (f == 3'd6) return a < b;
      if (f == 3'd7) return !(a < b);
      return 1'b0;
   endfunction

   task automatic drive_idle();
      valid_execute       = 1'b0;
      branch_execute      = 1'b0;
      jump_execute        = 1'b0;
      jump_reg_execute    = 1'b0;
      funct3_execute      = 3'd0;
      rs1_execute         = '0;
      rs2_execute         = '0;
      pc_plus_imm_execute = 32'h0000_0100;
      alu_result_execute  = 32'h0000_0200;
      stall_fetch         = 1'b0;
   endtask

   task automatic drive_branch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic st);
      drive_idle();
      valid_execute  = 1'b1;
      branch_execute = 1'b1;
      funct3_execute = f;
      rs1_execute    = a;
      rs2_execute    = b;
      stall_fetch    = st;
   endtask

   task automatic test_reset();
      drive_branch(3'd0, 32'd5, 32'd5, 1'b0);
      reset = 1'b1;
      sb_push(`PC_SRC_PC_PLUS_4, 1'b0);
      #1;
      e = sbq.pop_front();
      checks++;
      if (pc_source !== e.pc || flush_decode !== e.fd || flush_execute !== e.fe) begin
         failures++;
         $display("FAIL reset_outputs pc=%0d fd=%b fe=%b expected pc=%0d fd=%b fe=%b", pc_source, flush_decode, flush_execute, e.pc, e.fd, e.fe);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (branch_count !== 32'd0 || taken_count !== 32'd0 || misaligned_fetch !== 1'b0) begin
         failures++;
         $display("FAIL reset_state bc=%0h tc=%0h mis=%b expected 0 0 0", branch_count, taken_count, misaligned_fetch);
      end
      reset = 1'b0;
      drive_idle();
      exp_bc = 32'd0;
      exp_tc = 32'd0;
      @(negedge clk);
   endtask

   task automatic test_beq();
      drive_branch(3'd0, 32'd5, 32'd5, 1'b0);
      sb_push(`PC_SRC_PC_PLUS_IMM, 1'b1);
      exp_bc = exp_bc + 1;
      exp_tc = exp_tc + 1;
      #1;
      e = sbq.pop_front();
      checks++;
      if (pc_source !== e.pc || flush_decode !== e.fd || flush_execute !== e.fe) begin
         failures++;
         $display("FAIL beq_redirect pc=%0d fd=%b fe=%b expected pc=%0d fd=%b fe=%b", pc_source, flush_decode, flush_execute, e.pc, e.fd, e.fe);
      end
      @(negedge clk);
      drive_idle();
      checks++;
      if (branch_count !== 32'd1 || taken_count !== 32'd1) begin
         failures++;
         $display("FAIL beq_counts bc=%0d tc=%0d expected 1 1", branch_count, taken_count);
      end
   endtask

   task automatic test_conditions();
      logic [31:0] ops_a [4];
      logic [31:0] ops_b [4];
      logic        t;
      ops_a[0] = 32'd5;          ops_b[0] = 32'd5;
      ops_a[1] = 32'hFFFF_FFFF;  ops_b[1] = 32'd1;
      ops_a[2] = 32'd1;          ops_b[2] = 32'hFFFF_FFFF;
      ops_a[3] = 32'd3;          ops_b[3] = 32'd7;
      for (int f = 0; f < 8; f++) begin
         for (int p = 0; p < 4; p++) begin
            drive_branch(f[2:0], ops_a[p], ops_b[p], 1'b0);
            t = ref_taken(f[2:0], ops_a[p], ops_b[p]);
            sb_push(t ? `PC_SRC_PC_PLUS_IMM : `PC_SRC_PC_PLUS_4, t);
            exp_bc = exp_bc + 1;
            if (t) exp_tc = exp_tc + 1;
            #1;
            e = sbq.pop_front();
            checks++;
            if (pc_source !== e.pc || flush_decode !== e.fd || flush_execute !== e.fe) begin
               failures++;
               $display("FAIL cond_f%0d_p%0d pc=%0d fd=%b fe=%b expected pc=%0d fd=%b fe=%b", f, p, pc_source, flush_decode, flush_execute, e.pc, e.fd, e.fe);
            end
            @(negedge clk);
            checks++;
            if (branch_count !== exp_bc || taken_count !== exp_tc) begin
               failures++;
               $display("FAIL cond_counts_f%0d_p%0d bc=%0d tc=%0d expected %0d %0d", f, p, branch_count, taken_count, exp_bc, exp_tc);
            end
         end
      end
      drive_idle();
   endtask

   task automatic test_jalr_stall();
      drive_idle();
      valid_execute      = 1'b1;
      jump_reg_execute   = 1'b1;
      alu_result_execute = 32'h0000_1001;
      stall_fetch        = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) stall_fetch = 1'b0;
         if (i == 4) valid_execute = 1'b0;
         if (i == 3) sb_push(`PC_SRC_GPR_PLUS_IMM, 1'b1);
         else        sb_push(`PC_SRC_PC_PLUS_4, 1'b0);
         #1;
         e = sbq.pop_front();
         checks++;
         if (pc_source !== e.pc || flush_decode !== e.fd || flush_execute !== e.fe) begin
            failures++;
            $display("FAIL jalr_stall_c%0d pc=%0d fd=%b fe=%b expected pc=%0d fd=%b fe=%b", i, pc_source, flush_decode, flush_execute, e.pc, e.fd, e.fe);
         end
         @(negedge clk);
      end
      checks++;
      if (branch_count !== exp_bc || taken_count !== exp_tc || misaligned_fetch !== 1'b0) begin
         failures++;
         $display("FAIL jalr_side_effects bc=%0d tc=%0d mis=%b expected %0d %0d 0", branch_count, taken_count, misaligned_fetch, exp_bc, exp_tc);
      end
      drive_idle();
   endtask

   task automatic test_back_to_back();
      drive_branch(3'd1, 32'd1, 32'd2, 1'b1);
      sb_push(`PC_SRC_PC_PLUS_4, 1'b0);
      sb_push(`PC_SRC_PC_PLUS_IMM, 1'b1);
      sb_push(`PC_SRC_PC_PLUS_IMM, 1'b1);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) stall_fetch = 1'b0;
         if (i == 1) exp_tc = exp_tc + 1;
         if (i == 2) begin
            exp_bc = exp_bc + 1;
            exp_tc = exp_tc + 1;
         end
         #1;
         e = sbq.pop_front();
         checks++;
         if (pc_source !== e.pc || flush_decode !== e.fd || flush_execute !== e.fe) begin
            failures++;
            $display("FAIL b2b_c%0d pc=%0d fd=%b fe=%b expected pc=%0d fd=%b fe=%b", i, pc_source, flush_decode, flush_execute, e.pc, e.fd, e.fe);
         end
         @(negedge clk);
      end
      drive_idle();
      checks++;
      if (branch_count !== exp_bc || taken_count !== exp_tc) begin
         failures++;
         $display("FAIL b2b_counts bc=%0d tc=%0d expected %0d %0d", branch_count, taken_count, exp_bc, exp_tc);
      end
   endtask

   task automatic test_jal_misaligned();
      drive_idle();
      valid_execute       = 1'b1;
      jump_execute        = 1'b1;
      pc_plus_imm_execute = 32'h0000_0102;
      sb_push(`PC_SRC_PC_PLUS_4, 1'b0);
      #1;
      e = sbq.pop_front();
      checks++;
      if (pc_source !== e.pc || flush_decode !== e.fd || flush_execute !== e.fe) begin
         failures++;
         $display("FAIL jal_misaligned_noredirect pc=%0d fd=%b fe=%b expected pc=%0d fd=%b fe=%b", pc_source, flush_decode, flush_execute, e.pc, e.fd, e.fe);
      end
      @(negedge clk);
      drive_idle();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (misaligned_fetch !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_sticky_c%0d mis=%b expected 1", i, misaligned_fetch);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_saturation();
      drive_idle();
      force dut.branch_count = 32'hFFFF_FFFE;
      force dut.taken_count  = 32'hFFFF_FFFE;
      #1;
      release dut.branch_count;
      release dut.taken_count;
      exp_bc = 32'hFFFF_FFFE;
      exp_tc = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         drive_branch(3'd0, 32'd9, 32'd9, 1'b0);
         if (exp_bc != 32'hFFFF_FFFF) exp_bc = exp_bc + 1;
         if (exp_tc != 32'hFFFF_FFFF) exp_tc = exp_tc + 1;
         @(negedge clk);
         checks++;
         if (branch_count !== exp_bc || taken_count !== exp_tc) begin
            failures++;
            $display("FAIL saturate_c%0d bc=%0h tc=%0h expected %0h %0h", i, branch_count, taken_count, exp_bc, exp_tc);
         end
      end
      drive_idle();
   endtask

   task automatic test_reset_in_hold();
      drive_branch(3'd0, 32'd4, 32'd4, 1'b1);
      sb_push(`PC_SRC_PC_PLUS_4, 1'b0);
      sb_push(`PC_SRC_PC_PLUS_4, 1'b0);
      sb_push(`PC_SRC_PC_PLUS_4, 1'b0);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            reset       = 1'b1;
            stall_fetch = 1'b0;
         end
         if (i == 2) begin
            reset = 1'b0;
            drive_idle();
         end
         #1;
         e = sbq.pop_front();
         checks++;
         if (pc_source !== e.pc || flush_decode !== e.fd || flush_execute !== e.fe) begin
            failures++;
            $display("FAIL reset_hold_c%0d pc=%0d fd=%b fe=%b expected pc=%0d fd=%b fe=%b", i, pc_source, flush_decode, flush_execute, e.pc, e.fd, e.fe);
         end
         if (i == 2) begin
            checks++;
            if (branch_count !== 32'd0 || taken_count !== 32'd0 || misaligned_fetch !== 1'b0) begin
               failures++;
               $display("FAIL reset_hold_state bc=%0h tc=%0h mis=%b expected 0 0 0", branch_count, taken_count, misaligned_fetch);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (sbq.size() !== 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d expected 0", sbq.size());
      end
   endtask

   initial begin
      reset = 1'b1;
      drive_idle();
      exp_bc = 32'd0;
      exp_tc = 32'd0;
      @(negedge clk);
      test_reset();
      test_beq();
      test_conditions();
      test_jalr_stall();
      test_back_to_back();
      test_jal_misaligned();
      test_saturation();
      test_reset_in_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout expected completion before 100000");
      $fatal(1, "timeout");
   end

endmodule
